// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_receiver_sync_fifo.sv
// Count-based synchronous FIFO with show-ahead read data.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push-while-full succeeds with a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver feeding a small FIFO with a pop-style read port and level interrupt.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  input  logic       read_en,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clear_err,
  output logic       int_pending
);

  localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW   = $clog2(CPB);
  localparam int unsigned HALF = CPB / 2;

  uart_state_e state;
  uart_state_e next_state;

  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  logic half_hit;
  logic bit_hit;
  logic fifo_empty;
  logic fifo_full;

  logic cnt_clr_c;
  logic cnt_inc_c;
  logic idx_clr_c;
  logic idx_inc_c;
  logic shift_c;
  logic push_c;
  logic overrun_set_c;
  logic frame_set_c;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign half_hit = (clk_cnt == CW'(HALF - 1));
  assign bit_hit  = (clk_cnt == CW'(CPB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a held-low line never shows a new falling edge, so breaks stay idle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (half_hit) begin
          next_state = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_hit && (bit_idx == 3'd7)) begin
          next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath control strobes for the current state.
  always_comb begin
    cnt_clr_c     = 1'b0;
    cnt_inc_c     = 1'b0;
    idx_clr_c     = 1'b0;
    idx_inc_c     = 1'b0;
    shift_c       = 1'b0;
    push_c        = 1'b0;
    overrun_set_c = 1'b0;
    frame_set_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr_c = 1'b1;
      end
      ST_START: begin
        if (half_hit) begin
          cnt_clr_c = 1'b1;
          idx_clr_c = 1'b1;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          cnt_clr_c = 1'b1;
          shift_c   = 1'b1;
          idx_inc_c = 1'b1;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          cnt_clr_c = 1'b1;
          if (!rx_s) begin
            frame_set_c = 1'b1;
          end else if (!fifo_full || read_en) begin
            push_c = 1'b1;
          end else begin
            overrun_set_c = 1'b1;
          end
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      default: begin
        cnt_clr_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      if (cnt_clr_c) begin
        clk_cnt <= '0;
      end else if (cnt_inc_c) begin
        clk_cnt <= clk_cnt + CW'(1);
      end
      if (idx_clr_c) begin
        bit_idx <= '0;
      end else if (idx_inc_c) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_c) begin
        sh <= {rx_s, sh[7:1]};
      end
    end
  end

  // Sticky error flags; a same-cycle set beats clear_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set_c) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
      if (frame_set_c) begin
        frame_err <= 1'b1;
      end else if (clear_err) begin
        frame_err <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (read_en),
    .wdata (sh),
    .rdata (rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rdata_valid = !fifo_empty;
  assign int_pending = !fifo_empty;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames on a 16-clock/bit receiver with a 4-entry FIFO, checked against a queue model.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CPB   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       read_en;
  logic       overrun;
  logic       frame_err;
  logic       clear_err;
  logic       int_pending;

  int errors = 0;
  int checks = 0;

  // Reference model: the bytes the FIFO should hold and the sticky flags.
  logic [7:0] q [$];
  logic       m_ovr;
  logic       m_fe;

  uart_receiver #(
    .CLK_FREQ   (1_600_000),
    .BAUD_RATE  (100_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .read_en     (read_en),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .clear_err   (clear_err),
    .int_pending (int_pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " rdata_valid"}, 32'(rdata_valid), 32'(q.size() != 0));
    check({tag, " int_pending"}, 32'(int_pending), 32'(q.size() != 0));
    check({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, " frame_err"}, 32'(frame_err), 32'(m_fe));
    if (q.size() != 0) begin
      check({tag, " rdata"}, 32'(rdata), 32'(q[0]));
    end
  endtask

  // Drive one 8N1 frame; optionally pulse read_en during the stop-bit sample cycle.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit pop_at_stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(10);
    check("pre-stop valid", 32'(rdata_valid), 32'(q.size() != 0));
    if (pop_at_stop) read_en = 1'b1;
    tick(1);
    read_en = 1'b0;
    if (pop_at_stop && q.size() != 0) void'(q.pop_front());
    if (!stop_ok) m_fe = 1'b1;
    else if (q.size() < DEPTH) q.push_back(d);
    else m_ovr = 1'b1;
    check_state("post-stop");
    tick(5);
    rx = 1'b1;
    if (!stop_ok) tick(CPB);
  endtask

  task automatic read_byte();
    check_state("pre-read");
    read_en = 1'b1;
    tick(1);
    read_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_state("post-read");
  endtask

  task automatic clear_flags();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    check_state("clear");
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; rx = 1'b1; read_en = 1'b0; clear_err = 1'b0;
    m_ovr = 1'b0; m_fe = 1'b0;
    tick(3);
    check_state("in reset");
    rst = 1'b0;
    tick(4);
    check_state("after reset");

    // Single byte, then pop it.
    send_frame(8'hA5, 1'b1, 1'b0);
    check("A5 data", 32'(rdata), 32'h0000_00A5);
    read_byte();
    tick(8);

    // Back-to-back frames, drained in order.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(8);
    for (int i = 0; i < 3; i++) read_byte();

    // Short glitch on the idle line is rejected.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    check_state("glitch");
    send_frame(8'h42, 1'b1, 1'b0);
    read_byte();

    // Bad stop bit sets frame_err and drops the byte.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    tick(4);
    check_state("frame error");
    clear_flags();
    read_byte();

    // Overflow without reads, then a same-cycle pop that saves the fifth byte.
    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
    check("overrun set", 32'(overrun), 32'd1);
    clear_flags();
    while (q.size() != 0) read_byte();
    for (int i = 0; i < 4; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b0);
    send_frame(8'h24, 1'b1, 1'b1);
    check("no overrun", 32'(overrun), 32'd0);
    while (q.size() != 0) read_byte();

    // Randomized traffic with occasional bad stop bits, reads and clears.
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      send_frame(d, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
      tick($urandom_range(0, 20));
      for (int r = $urandom_range(0, 2); r > 0; r--) begin
        if (q.size() != 0) read_byte();
      end
      if ($urandom_range(0, 4) == 0) clear_flags();
    end

    // Reset in the middle of a frame loses the partial byte.
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    rx = 1'b0;
    tick(20);
    rst = 1'b1;
    tick(2);
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    check_state("mid-frame reset");
    rx = 1'b1;
    rst = 1'b0;
    tick(20);
    check_state("after mid-frame reset");
    send_frame(8'h7E, 1'b1, 1'b0);
    check("7E only", 32'(rdata), 32'h0000_007E);
    read_byte();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
